// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
//   Shared constants and helpers for the multi-port register file.
//
//   Contents:
//     DEF_DATA_W, DEF_ADDR_W, DEF_ZERO_REG : default parameter values
//     MAX_WR, MAX_ADDR_W                   : upper bounds used by wr_sel
//     addr_t                               : address zero-extended to MAX_ADDR_W
//     wr_sel_t                             : {hit, winning write-port index}
//     wr_sel()                             : highest-numbered enabled write port
//                                            that targets a given address
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 31;

    // wr_sel works on fixed-size vectors so one function serves every
    // parameterisation; callers zero-extend and tie unused ports off.
    localparam int MAX_WR     = 2;
    localparam int MAX_ADDR_W = 8;
    localparam int WR_IDX_W   = 1;

    typedef logic [MAX_ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] port;
    } wr_sel_t;

    // Later ports overwrite the result, so the highest-numbered matching
    // port wins a same-address conflict.
    function automatic wr_sel_t wr_sel(
        input logic  [MAX_WR-1:0]        en,
        input addr_t [MAX_WR-1:0]        addr,
        input addr_t                     target
    );
        wr_sel_t sel;
        sel = '0;
        for (int w = 0; w < MAX_WR; w++) begin
            if (en[w] && (addr[w] == target)) begin
                sel.hit  = 1'b1;
                sel.port = WR_IDX_W'(w);
            end
        end
        return sel;
    endfunction

endpackage : regfile_mp_pkg

// File: rtl/regfile_mp_rdport.sv
// -----------------------------------------------------------------------------
// regfile_mp_rdport
//   One combinational read port of regfile_mp. Instanced once per read port.
//
//   Build option:
//     REGFILE_MP_BYPASS_EN  defined   -> same-cycle write data is forwarded to
//                                        the read port (0-cycle write-to-read)
//                           undefined -> read returns the stored value only
//
//   Ports:
//     mem_i      in   DEPTH*DATA_W   storage array (registered contents)
//     busy_i     in   DEPTH          registered busy scoreboard
//     wr_en_i    in   MAX_WR         write enables (unused ports tied low)
//     wr_addr_i  in   MAX_WR addr_t  write addresses, zero-extended
//     wr_data_i  in   NUM_WR*DATA_W  write data
//     rsv_en_i   in   1              reserve request
//     rsv_addr_i in   ADDR_W         register being reserved
//     rd_addr_i  in   ADDR_W         read address for this port
//     rd_data_o  out  DATA_W         read data
//     rd_busy_o  out  1              busy bit of the addressed register
// -----------------------------------------------------------------------------
module regfile_mp_rdport
    import regfile_mp_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int NUM_WR   = 2,
    parameter  int ZERO_REG = DEF_ZERO_REG,
    localparam int DEPTH    = 2**ADDR_W
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
    input  logic [DEPTH-1:0]             busy_i,
    input  logic [MAX_WR-1:0]            wr_en_i,
    input  addr_t [MAX_WR-1:0]           wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]     wr_data_i,
    input  logic                         rsv_en_i,
    input  logic [ADDR_W-1:0]            rsv_addr_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         rd_busy_o
);

    logic is_zero_reg;
    assign is_zero_reg = (rd_addr_i == ADDR_W'(ZERO_REG));

`ifdef REGFILE_MP_BYPASS_EN
    wr_sel_t fwd_sel;
    assign fwd_sel = wr_sel(wr_en_i, wr_addr_i, addr_t'(rd_addr_i));
`else
    // Write-side inputs only matter when forwarding is built in.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i};
`endif

    // NOTE: every output gets a default at the top of the block, so no path
    // through the if-chain leaves a value held and no latch is inferred.
    always_comb begin
        rd_data_o = mem_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
`ifdef REGFILE_MP_BYPASS_EN
        // A write landing this edge resolves the hazard; the register stays
        // busy only if a new producer reserves it in the same cycle.
        if (fwd_sel.hit) begin
            rd_data_o = wr_data_i[fwd_sel.port*DATA_W +: DATA_W];
            rd_busy_o = rsv_en_i && (rsv_addr_i == rd_addr_i);
        end
`endif
        // Zero register masking has the final say, bypass or not.
        if (is_zero_reg) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
    end

endmodule : regfile_mp_rdport

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with a per-register busy
//   scoreboard, for the decode stage of a pipelined CPU. Writeback drives the
//   write ports; issue drives the reserve port to mark a destination busy.
//
//   Build option:
//     REGFILE_MP_BYPASS_EN  forwards same-cycle write data to the read ports
//                           (see regfile_mp_rdport); undefined by default.
//
//   Parameters:
//     DATA_W   register width            ADDR_W  address width, DEPTH=2**ADDR_W
//     NUM_RD   read ports (1..4)         NUM_WR  write ports (1..2)
//     ZERO_REG index hardwired to zero, never busy
//
//   Ports:
//     clk       in   1              rising-edge clock
//     reset     in   1              async active-high, clears data and busy
//     rd_addr   in   NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//     rd_data   out  NUM_RD*DATA_W  combinational read data
//     rd_busy   out  NUM_RD         busy bit of each addressed register
//     wr_en     in   NUM_WR         write enables
//     wr_addr   in   NUM_WR*ADDR_W  write addresses
//     wr_data   in   NUM_WR*DATA_W  write data
//     rsv_en    in   1              reserve request
//     rsv_addr  in   ADDR_W         register to mark busy
//     busy_vec  out  DEPTH          full scoreboard
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  int ZERO_REG = DEF_ZERO_REG,
    localparam int DEPTH    = 2**ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [DEPTH-1:0]           busy_vec
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             busy_q, busy_d;

    // Write ports widened to the fixed shape wr_sel expects; ports beyond
    // NUM_WR stay disabled.
    logic  [MAX_WR-1:0] wr_en_ext;
    addr_t [MAX_WR-1:0] wr_addr_ext;

    always_comb begin
        wr_en_ext   = '0;
        wr_addr_ext = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_en_ext[w]   = wr_en[w];
            wr_addr_ext[w] = addr_t'(wr_addr[w*ADDR_W +: ADDR_W]);
        end
    end

    // Next state for storage and scoreboard. Per register: a write stores
    // the winning port's data and clears busy; a reservation then sets busy,
    // so a new producer issued in the same cycle overrides the completion.
    always_comb begin
        wr_sel_t sel;
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            sel = wr_sel(wr_en_ext, wr_addr_ext, addr_t'(r));
            if (sel.hit) begin
                mem_d[r]  = wr_data[sel.port*DATA_W +: DATA_W];
                busy_d[r] = 1'b0;
            end
            if (rsv_en && (rsv_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        // Writes and reservations aimed at the zero register are discarded.
        mem_d[ZERO_REG]  = '0;
        busy_d[ZERO_REG] = 1'b0;
    end

    // NOTE: the storage array itself is reset here, not just the scoreboard:
    // every register must read 0 after reset, so this is a flop array rather
    // than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge values and the order of statements cannot matter.
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_mp_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .mem_i      (mem_q),
            .busy_i     (busy_q),
            .wr_en_i    (wr_en_ext),
            .wr_addr_i  (wr_addr_ext),
            .wr_data_i  (wr_data),
            .rsv_en_i   (rsv_en),
            .rsv_addr_i (rsv_addr),
            .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
            .rd_data_o  (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy_o  (rd_busy[p])
        );
    end

endmodule : regfile_mp
